// File: rtl/twos_sm_stream_encode.sv
// Two's complement -> signed-magnitude lane encoder; TWOS_SM_SAT_FSN_EN maps -256 to 9'h1FF instead of 9'h100.
// Latency 2 cycles, 1 beat/cycle; full valid/ready backpressure, s_ready falls only when both stages are stalled.
module twos_sm_stream_encode #(
  parameter int LANES = 8,
  parameter int DW    = 9,
  parameter int CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [LANES*DW-1:0]   s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [LANES*DW-1:0]   m_data,
  input  logic                  fsn_clr,
  output logic [CNT_W-1:0]      fsn_count
);

  localparam int PCW = $clog2(LANES + 1);
  localparam logic [DW-1:0] FSN_CODE = {1'b1, {(DW-1){1'b0}}};
`ifdef TWOS_SM_SAT_FSN_EN
  localparam logic [DW-1:0] FSN_OUT = {DW{1'b1}};
`else
  localparam logic [DW-1:0] FSN_OUT = FSN_CODE;
`endif

  generate
    if (DW != 9) begin : g_dw_check
      $error("twos_sm_stream_encode: DW must be 9");
    end
  endgenerate

  logic                v1, v2;
  logic                adv1, adv2;
  logic [LANES*DW-1:0] d1;
  logic [LANES-1:0]    neg1, fsn1;
  logic [LANES-1:0]    neg_in, fsn_in;
  logic [PCW-1:0]      fsn_pc;
  logic [LANES*DW-1:0] sm_res;
  logic [CNT_W:0]      cnt_sum;

  // s_ready depends on m_ready only, never on s_valid
  assign adv2    = v1 && (!v2 || m_ready);
  assign s_ready = !v1 || adv2;
  assign adv1    = s_valid && s_ready;
  assign m_valid = v2;

  always_comb begin
    neg_in = '0;
    fsn_in = '0;
    fsn_pc = '0;
    for (int i = 0; i < LANES; i++) begin
      neg_in[i] = s_data[i*DW + DW - 1];
      fsn_in[i] = (s_data[i*DW +: DW] == FSN_CODE);
      fsn_pc    = fsn_pc + PCW'(fsn_in[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1   <= 1'b0;
      d1   <= '0;
      neg1 <= '0;
      fsn1 <= '0;
    end else if (adv1) begin
      v1   <= 1'b1;
      d1   <= s_data;
      neg1 <= neg_in;
      fsn1 <= fsn_in;
    end else if (adv2) begin
      v1   <= 1'b0;
    end
  end

  always_comb begin
    sm_res = '0;
    for (int i = 0; i < LANES; i++) begin
      if (!neg1[i])
        sm_res[i*DW +: DW] = d1[i*DW +: DW];
      else if (fsn1[i])
        sm_res[i*DW +: DW] = FSN_OUT;
      else
        sm_res[i*DW +: DW] = {1'b1, (~d1[i*DW +: DW-1]) + (DW-1)'(1)};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v2     <= 1'b0;
      m_data <= '0;
    end else if (adv2) begin
      v2     <= 1'b1;
      m_data <= sm_res;
    end else if (m_ready) begin
      v2     <= 1'b0;
    end
  end

  // Extra top bit catches overflow so the counter saturates instead of wrapping
  assign cnt_sum = {1'b0, fsn_count} + (CNT_W+1)'(fsn_pc);

  always_ff @(posedge clk) begin
    if (rst || fsn_clr)
      fsn_count <= '0;
    else if (adv1)
      fsn_count <= cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
  end

endmodule

// File: doc/twos_sm_stream_encode.md
Name: twos_sm_stream_encode

Overview:
- Streaming converter from 9-bit two's complement lanes to 9-bit signed magnitude: bit 8 is the sign, bits 7:0 the magnitude.
- Sits on the output side of the int8 OS processing kernel and packs results for the signed-magnitude consumers.
- It is the exact inverse of the existing SM-to-two's-complement decode. By codebase convention, SM code 9'h100 ("negative zero") decodes to -256, so -256 encodes to 9'h100.
- Two-stage valid/ready pipeline with full backpressure, plus a full-scale-negative event counter.

Parameters:
- LANES, 8, number of 9-bit lanes per beat.
- DW, 9, lane width. Fixed at 9; any other value is a synthesis-time error.
- CNT_W, 32, width of the full-scale-negative event counter.

Ports:
- clk  in  1  kernel clock.
- rst  in  1  synchronous reset, active-high.
- s_valid  in  1  input beat valid.
- s_ready  out  1  input beat accepted when s_valid && s_ready.
- s_data  in  LANES*DW  two's complement lanes; lane i occupies bits [i*9 +: 9].
- m_valid  out  1  output beat valid.
- m_ready  in  1  downstream ready.
- m_data  out  LANES*DW  signed-magnitude lanes, same packing as s_data.
- fsn_clr  in  1  synchronous clear of fsn_count.
- fsn_count  out  CNT_W  running count of lanes equal to -256 (9'h100) that were accepted.

Behaviour:
- Reset values: m_valid=0, m_data=0, fsn_count=0. Both internal stage valids (v1, v2) are 0. s_ready=1 in the first cycle after reset.
- Pipeline structure:
  - Stage 1 registers s_data together with per-lane flags: neg = bit 8, fsn = (lane == 9'h100).
  - Stage 2 computes and registers the SM result; m_data and m_valid are driven directly from stage-2 registers.
- Advance rules:
  - adv2 = v1 && (!v2 || m_ready).
  - adv1 = s_valid && s_ready.
  - s_ready = !v1 || adv2. This is combinational from m_ready; no path runs from s_valid to s_ready.
- Latency: a beat accepted at clock edge N appears on m_data/m_valid after edge N+1 when unstalled. Sustained throughput is 1 beat/cycle with m_ready held high.
- Stall: while m_valid && !m_ready, m_data is held stable and m_valid stays 1.
  - The pipeline holds at most 2 beats.
  - With both stages full, s_ready drops to 0.
- Per-lane conversion, input x:
  - x[8]==0: output = x unchanged. Positive values and zero map through; output is never 9'h100 for zero.
  - x[8]==1 and x != 9'h100: output = {1'b1, (~x[7:0]) + 1}, with magnitude taken mod 2^8. Examples: -1 (9'h1FF) -> 9'h101; -255 (9'h101) -> 9'h1FF.
  - x == 9'h100 (-256): output = 9'h100. See Optional Feature for the alternative.
- fsn_count:
  - On each adv1, adds popcount of lanes equal to 9'h100.
  - Saturates at 2^CNT_W-1; no wrap.
  - fsn_clr has priority over a same-cycle increment: the result is 0 and that cycle's increment is dropped.
- Reset mid-operation: any in-flight beats are discarded and no partial beat is emitted. fsn_count clears.
- Simultaneous accept and emit at full occupancy (m_ready=1): both stages advance in the same cycle, with no bubble and no data loss.
- Ordering is strictly preserved.

Optional Feature:
- Macro: TWOS_SM_SAT_FSN_EN.
- Defined:
  - -256 saturates to 9'h1FF (-255), making every output a symmetric-range SM code.
  - fsn_count still counts these lanes, which now means "saturation events".
- Undefined:
  - -256 maps to 9'h100, an exact inverse of the SM decode (round-trip bijective over all 512 codes).
  - fsn_count counts -256 lanes.

Test Plan:
- Exhaustive round trip, macro undefined: stream all 512 codes (64 beats, 8 lanes) with m_ready=1. Feed each output through the SM decode -> equals the input for every code. fsn_count=1. First m_valid appears exactly 2 cycles after the first accept.
- Spot values: lanes {0, 1, 255, 9'h1FF(-1), 9'h101(-255), 9'h180(-128), 9'h100, 9'h100} -> {9'h000, 9'h001, 9'h0FF, 9'h101, 9'h1FF, 9'h180, 9'h100, 9'h100}. fsn_count increments by 2.
- Backpressure: m_ready=0 for 5 cycles while s_valid=1 -> exactly 2 beats accepted, then s_ready=0 and m_data stable. Release m_ready -> beats emerge in order with no duplicates or drops. Random m_ready at 50% over 1000 beats -> output sequence matches the scoreboard.
- Counter saturation and clear: preload fsn_count to 2^CNT_W-2 via CNT_W=4 with 14 fsn lanes, then send a beat with 3 fsn lanes -> fsn_count=15 and holds. Assert fsn_clr in the same cycle as an fsn accept -> fsn_count=0.
- Reset mid-stream: assert rst with both stages full -> next cycle m_valid=0, s_ready=1, fsn_count=0. No stale beat is emitted afterward.
- Macro defined: input 9'h100 -> 9'h1FF and fsn_count+1. Input 9'h1FF -> 9'h101, unchanged from the undefined build.
